// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } state_e;

    localparam logic [7:0] MMIO_ADDR     = 8'hFF;
    localparam int         BURST_LEN_DEF = 4;
    localparam int         WAIT_CNT_W    = 4;

endpackage

// File: rtl/ram_256x8.sv
// 256x8 data RAM: synchronous write, combinational (asynchronous) read, no reset.
// Latency: write visible to the read port the cycle after the write edge.
// Backpressure: none; one write and one read per cycle.
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module ram_256x8 (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [256];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the 8-bit data-memory bus: single-byte reads/writes and BURST_LEN-beat burst reads.
// Latency: beat k of a read accepted at edge t is valid in cycle t+1+WAIT_CYCLES+k; writes take one cycle.
// Backpressure: ready is high only in IDLE; requests while ready=0 are dropped, never queued.
// Ports: clock/reset_n (async active-low); mem_read/mem_write/burst/address/data request side;
//        q/q_valid returned beats; ready accept strobe; sw/led memory-mapped I/O at 0xFF.
// Optional feature: define MEM_MMIO_EN to map address 0xFF onto sw (read) and led (write);
//        otherwise 0xFF is plain RAM, led is tied to 0 and sw is ignored.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int BURST_LEN   = BURST_LEN_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       burst,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic [4:0] sw,
    output logic [7:0] q,
    output logic       q_valid,
    output logic       ready,
    output logic [7:0] led
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_e                 state_q, state_d;
    logic [7:0]             ptr_q, ptr_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
    logic [7:0]             q_q, q_d;
    logic                   q_valid_q, q_valid_d;

    logic                   accept_wr;
    logic                   accept_rd;
    logic                   ram_we;
    logic [7:0]             ram_raddr;
    logic [7:0]             ram_rdata;
    logic [7:0]             fetch_data;
    logic [CNT_W-1:0]       beat_total;

    // Write wins over a simultaneous read; the read is simply dropped.
    assign accept_wr  = (state_q == IDLE) && mem_write;
    assign accept_rd  = (state_q == IDLE) && mem_read && !mem_write;
    assign beat_total = burst ? CNT_W'(BURST_LEN) : CNT_W'(1);

    // In IDLE the first beat may be fetched straight from the request address;
    // afterwards ptr_q always holds the address of the next beat to fetch.
    assign ram_raddr = (state_q == IDLE) ? address : ptr_q;

`ifdef MEM_MMIO_EN
    logic [7:0] led_q, led_d;

    assign ram_we     = accept_wr && (address != MMIO_ADDR);
    assign fetch_data = (ram_raddr == MMIO_ADDR) ? {3'b000, sw} : ram_rdata;
    assign led_d      = (accept_wr && (address == MMIO_ADDR)) ? data : led_q;
    assign led        = led_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end
`else
    logic unused_sw;

    assign ram_we     = accept_wr;
    assign fetch_data = ram_rdata;
    assign led        = 8'h00;
    assign unused_sw  = ^sw;
`endif

    ram_256x8 u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .waddr_i (address),
        .wdata_i (data),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // q/q_valid are registered, so each beat is loaded on the edge that opens
    // its BEAT cycle. beat_q counts beats still to be fetched; the final BEAT
    // cycle is the one where it has reached zero.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        q_d       = q_q;
        q_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_rd) begin
                    if (WAIT_CYCLES == 0) begin
                        q_d       = fetch_data;
                        q_valid_d = 1'b1;
                        ptr_d     = address + 8'd1;
                        beat_d    = beat_total - 1'b1;
                        state_d   = BEAT;
                    end else begin
                        ptr_d     = address;
                        beat_d    = beat_total;
                        wait_d    = WAIT_CNT_W'(WAIT_CYCLES - 1);
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    q_d       = fetch_data;
                    q_valid_d = 1'b1;
                    ptr_d     = ptr_q + 8'd1;
                    beat_d    = beat_q - 1'b1;
                    state_d   = BEAT;
                end else begin
                    wait_d    = wait_q - 1'b1;
                end
            end
            BEAT: begin
                if (beat_q != '0) begin
                    q_d       = fetch_data;
                    q_valid_d = 1'b1;
                    ptr_d     = ptr_q + 8'd1;
                    beat_d    = beat_q - 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 8'h00;
            beat_q    <= '0;
            wait_q    <= '0;
            q_q       <= 8'h00;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with no wait states, one with three.
// Expected beats (data and cycle) are queued when a read is issued and checked by a
// negedge monitor when q_valid is seen.
module tb_data_mem_responder;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic [4:0] sw      = 5'b10101;

    logic       rd0, wr0, bu0;
    logic [7:0] ad0, da0, q0, led0;
    logic       qv0, rdy0;

    logic       rd3, wr3, bu3;
    logic [7:0] ad3, da3, q3, led3;
    logic       qv3, rdy3;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    exp_t sb0[$];
    exp_t sb3[$];
    exp_t e0, e3;

    logic [7:0] mdl0 [256];
    logic [7:0] mdl3 [256];
    logic [7:0] led_exp0 = 8'h00;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .mem_read(rd0), .mem_write(wr0), .burst(bu0),
        .address(ad0), .data(da0), .sw(sw), .q(q0), .q_valid(qv0), .ready(rdy0), .led(led0)
    );

    data_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .mem_read(rd3), .mem_write(wr3), .burst(bu3),
        .address(ad3), .data(da3), .sw(sw), .q(q3), .q_valid(qv3), .ready(rdy3), .led(led3)
    );

    // Scoreboard monitors: every q_valid beat must match the head of its queue in data and cycle.
    always @(negedge clock) begin
        if (qv0 === 1'b1) begin
            vectors++;
            if (sb0.size() == 0) begin
                miscompares++;
                $display("FAIL dut0_unexpected_beat got q=%h at cycle %0d, expected no beat", q0, cyc);
            end else begin
                e0 = sb0.pop_front();
                if (q0 !== e0.d || cyc != e0.cyc) begin
                    miscompares++;
                    $display("FAIL dut0_beat got q=%h cycle %0d, expected q=%h cycle %0d", q0, cyc, e0.d, e0.cyc);
                end
            end
        end
        if (qv3 === 1'b1) begin
            vectors++;
            if (sb3.size() == 0) begin
                miscompares++;
                $display("FAIL dut3_unexpected_beat got q=%h at cycle %0d, expected no beat", q3, cyc);
            end else begin
                e3 = sb3.pop_front();
                if (q3 !== e3.d || cyc != e3.cyc) begin
                    miscompares++;
                    $display("FAIL dut3_beat got q=%h cycle %0d, expected q=%h cycle %0d", q3, cyc, e3.d, e3.cyc);
                end
            end
        end
    end

    function automatic logic [7:0] exp_rd0(input logic [7:0] a);
`ifdef MEM_MMIO_EN
        if (a == 8'hFF) return {3'b000, sw};
`endif
        return mdl0[a];
    endfunction

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic do_wr0(input logic [7:0] a, input logic [7:0] d);
        wr0 = 1'b1; ad0 = a; da0 = d;
        @(posedge clock); #1;
        wr0 = 1'b0;
`ifdef MEM_MMIO_EN
        if (a == 8'hFF) led_exp0 = d;
        else mdl0[a] = d;
`else
        mdl0[a] = d;
`endif
    endtask

    task automatic do_rd0(input logic [7:0] a, input logic b);
        int n = b ? 4 : 1;
        for (int k = 0; k < n; k++) sb0.push_back(exp_t'{exp_rd0(a + 8'(k)), cyc + 1 + k});
        rd0 = 1'b1; bu0 = b; ad0 = a;
        @(posedge clock); #1;
        rd0 = 1'b0; bu0 = 1'b0;
    endtask

    task automatic do_wr3(input logic [7:0] a, input logic [7:0] d);
        wr3 = 1'b1; ad3 = a; da3 = d;
        @(posedge clock); #1;
        wr3 = 1'b0;
        mdl3[a] = d;
    endtask

    task automatic do_rd3(input logic [7:0] a);
        sb3.push_back(exp_t'{mdl3[a], cyc + 4});
        rd3 = 1'b1; bu3 = 1'b0; ad3 = a;
        @(posedge clock); #1;
        rd3 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (rdy0 !== 1'b1) begin
            if (n == 40) begin
                vectors++; miscompares++;
                $display("FAIL dut0_idle_timeout got ready=%b, expected 1 within 40 cycles", rdy0);
                break;
            end
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic wait_idle3();
        int n = 0;
        while (rdy3 !== 1'b1) begin
            if (n == 40) begin
                vectors++; miscompares++;
                $display("FAIL dut3_idle_timeout got ready=%b, expected 1 within 40 cycles", rdy3);
                break;
            end
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #20 reset_n = 1'b1;
        @(posedge clock); #1;
        vectors++; if (rdy0 !== 1'b1)  begin miscompares++; $display("FAIL reset_ready0 got %b, expected 1", rdy0); end
        vectors++; if (q0 !== 8'h00)   begin miscompares++; $display("FAIL reset_q0 got %h, expected 00", q0); end
        vectors++; if (qv0 !== 1'b0)   begin miscompares++; $display("FAIL reset_qvalid0 got %b, expected 0", qv0); end
        vectors++; if (led0 !== 8'h00) begin miscompares++; $display("FAIL reset_led0 got %h, expected 00", led0); end
        vectors++; if (rdy3 !== 1'b1)  begin miscompares++; $display("FAIL reset_ready3 got %b, expected 1", rdy3); end
        vectors++; if (q3 !== 8'h00)   begin miscompares++; $display("FAIL reset_q3 got %h, expected 00", q3); end
    endtask

    task automatic test_single_read();
        do_wr0(8'h11, 8'hA5);
        do_wr0(8'h10, 8'h5A);
        do_rd0(8'h10, 1'b0);  // read-after-write on the very next cycle
        vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL single_ready_during_beat got %b, expected 0", rdy0); end
        @(posedge clock); #1;
        vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL single_ready_after got %b, expected 1", rdy0); end
        vectors++; if (q0 !== 8'h5A || qv0 !== 1'b0) begin
            miscompares++; $display("FAIL single_q_hold got q=%h valid=%b, expected q=5a valid=0", q0, qv0);
        end
        do_rd0(8'h11, 1'b0);
        wait_idle0();
    endtask

    task automatic test_burst_wrap();
        int c0;
        do_wr0(8'hFE, 8'h11);
        do_wr0(8'hFF, 8'h22);
        do_wr0(8'h00, 8'h33);
        do_wr0(8'h01, 8'h44);
        do_rd0(8'hFE, 1'b1);
        c0 = cyc;
        wait_idle0();
        vectors++; if (cyc != c0 + 4) begin
            miscompares++; $display("FAIL burst_busy_len got %0d busy cycles, expected 4", cyc - c0);
        end
    endtask

    task automatic test_wait_states();
        do_wr3(8'h30, 8'hA1);
        do_rd3(8'h30);
        vectors++; if (rdy3 !== 1'b0) begin miscompares++; $display("FAIL wait_ready_busy got %b, expected 0", rdy3); end
        // Write while busy must be ignored, model is left untouched.
        wr3 = 1'b1; ad3 = 8'h30; da3 = 8'hEE;
        @(posedge clock); #1;
        wr3 = 1'b0;
        wait_idle3();
        do_rd3(8'h30);
        wait_idle3();
    endtask

    task automatic test_rw_collision();
        rd0 = 1'b1; wr0 = 1'b1; ad0 = 8'h20; da0 = 8'h77;
        @(posedge clock); #1;
        rd0 = 1'b0; wr0 = 1'b0;
        mdl0[8'h20] = 8'h77;
        vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL collision_ready got %b, expected 1", rdy0); end
        repeat (3) begin @(posedge clock); #1; end
        do_rd0(8'h20, 1'b0);
        wait_idle0();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 4; i++) do_wr0(8'h40 + 8'(i), 8'hC0 + 8'(i));
        sb0.push_back(exp_t'{mdl0[8'h40], cyc + 1});  // only beat 0 survives
        rd0 = 1'b1; bu0 = 1'b1; ad0 = 8'h40;
        @(posedge clock); #1;
        rd0 = 1'b0; bu0 = 1'b0;
        @(posedge clock); #1;          // second beat now on the bus
        reset_n = 1'b0;
        #1;
        vectors++; if (qv0 !== 1'b0) begin miscompares++; $display("FAIL midburst_abort_valid got %b, expected 0", qv0); end
        #19 reset_n = 1'b1;
        repeat (6) begin @(posedge clock); #1; end
        vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL midburst_ready got %b, expected 1", rdy0); end
        vectors++; if (q0 !== 8'h00)  begin miscompares++; $display("FAIL midburst_q_reset got %h, expected 00", q0); end
        vectors++; if (sb0.size() != 0) begin miscompares++; $display("FAIL midburst_beat0 got %0d pending, expected 0", sb0.size()); end
        do_rd0(8'h41, 1'b0);           // RAM survives reset
        wait_idle0();
    endtask

    task automatic test_mmio();
        sw = 5'b10101;
        do_wr0(8'hFF, 8'h3C);
`ifdef MEM_MMIO_EN
        vectors++; if (led0 !== 8'h3C) begin miscompares++; $display("FAIL mmio_led got %h, expected 3c", led0); end
`else
        vectors++; if (led0 !== 8'h00) begin miscompares++; $display("FAIL mmio_led got %h, expected 00", led0); end
`endif
        vectors++; if (led0 !== led_exp0) begin miscompares++; $display("FAIL mmio_led_model got %h, expected %h", led0, led_exp0); end
        do_rd0(8'hFF, 1'b0);           // 0x15 with MMIO, 0x3C as plain RAM
        wait_idle0();
    endtask

    initial begin
        rd0 = 1'b0; wr0 = 1'b0; bu0 = 1'b0; ad0 = 8'h00; da0 = 8'h00;
        rd3 = 1'b0; wr3 = 1'b0; bu3 = 1'b0; ad3 = 8'h00; da3 = 8'h00;

        test_reset();
        test_single_read();
        test_burst_wrap();
        test_wait_states();
        test_rw_collision();
        test_reset_mid_burst();
        test_mmio();

        repeat (4) begin @(posedge clock); #1; end
        vectors++; if (sb0.size() != 0) begin miscompares++; $display("FAIL dut0_missing_beats got %0d pending, expected 0", sb0.size()); end
        vectors++; if (sb3.size() != 0) begin miscompares++; $display("FAIL dut3_missing_beats got %0d pending, expected 0", sb3.size()); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion, expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
